// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage.
//   fetch_t : one fetched instruction, {pc, ir}
//   NOP     : addi x0,x0,0, presented when nothing is buffered
//   state_t : fetch FSM states
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched instructions between the memory response and decode.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write one entry (caller never pushes into a full buffer)
//   pop        : remove the head entry (ignored when empty)
//   flush      : drop all entries; overrides push and pop
//   head       : head entry, or {0, NOP} when empty
//   count      : number of valid entries
//   empty      : no valid entries
import fetch_pkg::*;

module fetch_buffer #(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_t        din,
  output fetch_t        head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;
  logic          full;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop && !empty;
  assign head   = empty ? fetch_t'{pc: 32'h0, ir: NOP} : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= bump(wr_ptr);
      if (pop_ok) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // The credit check upstream must keep a slot free for every read in flight.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory and streams {pc, ir} to decode over valid/ready.
// Ports:
//   aclk, aresetn    : clock, asynchronous active-low reset
//   bubble           : control transfer pending in decode; stop and await redirect
//   stall            : load-use hazard; issue nothing new
//   redirect_valid   : execute resolved a control transfer this cycle
//   redirect_addr    : new PC (bits [1:0] ignored)
//   imem_req/addr    : read strobe and word address to instruction memory
//   imem_rdata       : read data, one cycle after imem_req
//   out_tvalid/ready : handshake to decode
//   out_pc, out_ir   : presented instruction (0 / NOP when nothing valid)
import fetch_pkg::*;

module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        bubble,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [31:0] out_pc,
  output logic [31:0] out_ir
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic          inflight;
  logic          squash;
  logic          push;
  logic          pop;
  logic          issue;
  logic [CW-1:0] count;
  logic          empty;
  logic [CW:0]   credit_used;
  fetch_t        head;

  assign pop    = out_tvalid && out_tready;
  // A response landing in a redirect cycle belongs to the wrong path.
  assign squash = redirect_valid && inflight;
  assign push   = inflight && !squash;

  // Slots committed: buffered entries not leaving this cycle plus the read in flight.
  assign credit_used = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (!redirect_valid && bubble) begin
          state_nxt = HOLD;
        end else if (!redirect_valid && !stall && (credit_used < (CW+1)'(DEPTH))) begin
          issue = 1'b1;
        end
      end
      HOLD: if (redirect_valid) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_req  = issue;
  assign imem_addr = pc;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= BOOT;
      pc       <= RESET_ADDR;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (redirect_valid) pc <= {redirect_addr[31:2], 2'b00};
      else if (issue)     pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge aclk) begin
    if (issue) resp_pc <= pc;
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fetch_t'{pc: resp_pc, ir: imem_rdata}),
    .head  (head),
    .count (count),
    .empty (empty)
  );

  assign out_tvalid = !empty;
  assign out_pc     = head.pc;
  assign out_ir     = head.ir;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch. The memory model returns ~addr as the instruction
// word, so every expected out_ir follows from the expected out_pc.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        aclk;
  logic        aresetn;
  logic        bubble;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_tvalid;
  logic        out_tready;
  logic [31:0] out_pc;
  logic [31:0] out_ir;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        tready;
    logic        stall;
    logic        bubble;
    logic        rv;
    logic [31:0] raddr;
    logic        req;
    logic [31:0] addr;
    logic        tvalid;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  fetch #(.RESET_ADDR(32'h0), .DEPTH(2)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .bubble         (bubble),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_tvalid     (out_tvalid),
    .out_tready     (out_tready),
    .out_pc         (out_pc),
    .out_ir         (out_ir)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (imem_req) imem_rdata <= ~imem_addr;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic tr, input logic st, input logic bu, input logic rv,
                     input logic [31:0] ra, input logic req, input logic [31:0] addr,
                     input logic tv, input logic [31:0] pc);
    vec_t v;
    v.tready = tr; v.stall = st; v.bubble = bu; v.rv = rv; v.raddr = ra;
    v.req = req; v.addr = addr; v.tvalid = tv; v.pc = pc;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance a clock.
  task automatic apply(input string tag, input vec_t v);
    out_tready     = v.tready;
    stall          = v.stall;
    bubble         = v.bubble;
    redirect_valid = v.rv;
    redirect_addr  = v.raddr;
    #1;
    chk({tag, " imem_req"},   {31'h0, imem_req},   {31'h0, v.req});
    if (v.req) chk({tag, " imem_addr"}, imem_addr, v.addr);
    chk({tag, " out_tvalid"}, {31'h0, out_tvalid}, {31'h0, v.tvalid});
    chk({tag, " out_pc"},     out_pc, v.tvalid ? v.pc : 32'h0);
    chk({tag, " out_ir"},     out_ir, v.tvalid ? ~v.pc : NOP);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    vec_t v;
    aresetn = 1'b0;
    bubble = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0;
    out_tready = 1'b1;

    //          tr st bu rv raddr          req addr           tv pc
    // streaming after reset, one instruction per cycle
    add(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h4,          0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'hC,          1, 32'h4);
    add(1, 0, 0, 0, 32'h0,          1, 32'h10,         1, 32'h8);
    // backpressure for 5 cycles: fills to DEPTH, then no requests
    add(0, 0, 0, 0, 32'h0,          0, 32'h14,         1, 32'hC);
    add(0, 0, 0, 0, 32'h0,          0, 32'h14,         1, 32'hC);
    add(0, 0, 0, 0, 32'h0,          0, 32'h14,         1, 32'hC);
    add(0, 0, 0, 0, 32'h0,          0, 32'h14,         1, 32'hC);
    add(0, 0, 0, 0, 32'h0,          0, 32'h14,         1, 32'hC);
    add(1, 0, 0, 0, 32'h0,          1, 32'h14,         1, 32'hC);
    add(1, 0, 0, 0, 32'h0,          1, 32'h18,         1, 32'h10);
    add(1, 0, 0, 0, 32'h0,          1, 32'h1C,         1, 32'h14);
    add(1, 0, 0, 0, 32'h0,          1, 32'h20,         1, 32'h18);
    // stall 2 cycles: PC frozen at 0x24, queued words drain
    add(1, 1, 0, 0, 32'h0,          0, 32'h24,         1, 32'h1C);
    add(1, 1, 0, 0, 32'h0,          0, 32'h24,         1, 32'h20);
    add(1, 0, 0, 0, 32'h0,          1, 32'h24,         0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h28,         0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h2C,         1, 32'h24);
    // bubble, HOLD, redirect 3 cycles later to 0x103
    add(1, 0, 1, 0, 32'h0,          0, 32'h30,         1, 32'h28);
    add(1, 0, 1, 0, 32'h0,          0, 32'h30,         1, 32'h2C);
    add(1, 0, 0, 0, 32'h0,          0, 32'h30,         0, 32'h0);
    add(1, 0, 0, 1, 32'h103,        0, 32'h30,         0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h100,        0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h104,        0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h108,        1, 32'h100);
    add(1, 0, 0, 0, 32'h0,          1, 32'h10C,        1, 32'h104);
    // redirect + stall while 0x10C is in flight: 0x10C never presented
    add(1, 1, 0, 1, 32'h40,         0, 32'h110,        1, 32'h108);
    add(1, 0, 0, 0, 32'h0,          1, 32'h40,         0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h44,         0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h48,         1, 32'h40);
    // redirect to the top word: PC wraps to 0
    add(1, 0, 0, 1, 32'hFFFF_FFFC,  0, 32'h4C,         1, 32'h44);
    add(1, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFFC);
    add(1, 0, 0, 0, 32'h0,          1, 32'h8,          1, 32'h0);

    // reset values while held in reset
    repeat (2) @(posedge aclk);
    #1;
    chk("rst imem_req",   {31'h0, imem_req},   32'h0);
    chk("rst imem_addr",  imem_addr,           32'h0);
    chk("rst out_tvalid", {31'h0, out_tvalid}, 32'h0);
    chk("rst out_pc",     out_pc,              32'h0);
    chk("rst out_ir",     out_ir,              NOP);
    aresetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("v%0d", i), vecs[i]);

    // reset pulsed mid-run with a read in flight
    aresetn = 1'b0;
    #1;
    chk("mid-rst imem_req",   {31'h0, imem_req},   32'h0);
    chk("mid-rst imem_addr",  imem_addr,           32'h0);
    chk("mid-rst out_tvalid", {31'h0, out_tvalid}, 32'h0);
    chk("mid-rst out_ir",     out_ir,              NOP);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    v = '{tready: 1, stall: 0, bubble: 0, rv: 0, raddr: 0, req: 0, addr: 0, tvalid: 0, pc: 0};
    apply("post-rst boot", v);
    v.req = 1'b1;
    apply("post-rst issue0", v);
    v.addr = 32'h4;
    apply("post-rst issue4", v);
    v.addr = 32'h8; v.tvalid = 1'b1; v.pc = 32'h0;
    apply("post-rst first", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
